// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACCEPT = 2'd1,
    WAIT_DONE   = 2'd2,
    GAP         = 2'd3
  } arb_state_e;

  localparam int unsigned UART_BIT_MAX = 8;
  localparam int unsigned UART_BPS_MAX = 5208;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set candidate searching upward from last+1, wrapping.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] win
);

  logic [IDX_W-1:0] idx;

  // Scan the N_REQ positions after last; the first hit wins
  always_comb begin
    valid = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((32'(last) + k) % N_REQ);
      if (!valid && cand[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of one UART byte transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned BIT_MAX        = UART_BIT_MAX,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned ACCEPT_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BIT_MAX-1:0] req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         grant,
  output logic [BIT_MAX-1:0]       tx_data,
  output logic                     tx_start,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned ACC_W = $clog2(ACCEPT_TIMEOUT + 1);

  arb_state_e       state;
  logic             locked;
  logic [IDX_W-1:0] last;
  logic [ACC_W-1:0] acc_cnt;
  logic [15:0]      gap_cnt;

  logic [N_REQ-1:0] cand;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_win;

  // Candidates: all requests, or only the packet owner while a packet is open
  always_comb begin
    cand = req;
    if (locked) cand = req & (N_REQ'(1) << last);
  end

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .cand  (cand),
    .last  (last),
    .valid (pick_valid),
    .win   (pick_win)
  );

  assign busy = (state != IDLE);

  // Arbitration FSM; ack/tx_start are single-cycle pulses issued only on an IDLE win
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      locked   <= 1'b0;
      last     <= IDX_W'(N_REQ - 1);
      acc_cnt  <= '0;
      gap_cnt  <= '0;
      ack      <= '0;
      grant    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            tx_data  <= req_data[32'(pick_win) * BIT_MAX +: BIT_MAX];
            tx_start <= 1'b1;
            ack      <= N_REQ'(1) << pick_win;
            grant    <= N_REQ'(1) << pick_win;
            last     <= pick_win;
            locked   <= !req_last[pick_win];
            acc_cnt  <= '0;
            state    <= WAIT_ACCEPT;
          end
        end
        WAIT_ACCEPT: begin
          if (!tx_ready) begin
            state <= WAIT_DONE;
          end else if (acc_cnt + ACC_W'(1) == ACC_W'(ACCEPT_TIMEOUT)) begin
            err    <= 1'b1;
            locked <= 1'b0;
            grant  <= '0;
            state  <= IDLE;
          end else begin
            acc_cnt <= acc_cnt + ACC_W'(1);
          end
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            if (!locked) grant <= '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus random traffic vs. a round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned N         = 4;
  localparam int unsigned W         = 8;
  localparam int          BYTE_CLKS = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [N-1:0]   req      = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack, grant;
  logic [W-1:0]   tx_data;
  logic           tx_start, tx_ready, busy, err;
  logic           tx_dead = 1'b0;
  int             tx_cnt;

  logic [N-1:0]   g_req  = '0;
  logic [N-1:0]   g_last = '0;
  logic [N*W-1:0] g_data = '0;
  logic [N-1:0]   g_ack, g_grant;
  logic [W-1:0]   g_tx_data;
  logic           g_tx_start, g_tx_ready, g_busy, g_err;
  int             g_tx_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int  m_last    = N - 1;
  bit  m_lock    = 1'b0;
  int  served[$];
  int  start_delta[$];
  int  last_rise = -1000;
  logic prev_rdy = 1'b1;

  int b, hold, g_rise, g_start;
  bit seen_low;
  int t2_exp[5] = '{0, 1, 2, 3, 0};
  int t3_exp[4] = '{2, 2, 2, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural transmitter: accepts tx_start when idle, busy for BYTE_CLKS clocks
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ready <= 1'b1;
      tx_cnt   <= 0;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_ready <= 1'b1;
    end else if (tx_start && !tx_dead) begin
      tx_ready <= 1'b0;
      tx_cnt   <= BYTE_CLKS;
    end
  end

  // Second transmitter for the gap-configured instance
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_tx_ready <= 1'b1;
      g_tx_cnt   <= 0;
    end else if (g_tx_cnt != 0) begin
      g_tx_cnt <= g_tx_cnt - 1;
      if (g_tx_cnt == 1) g_tx_ready <= 1'b1;
    end else if (g_tx_start) begin
      g_tx_ready <= 1'b0;
      g_tx_cnt   <= BYTE_CLKS;
    end
  end

  uart_tx_arbiter #(
    .N_REQ(N), .BIT_MAX(W), .GAP_CYCLES(0), .ACCEPT_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .busy(busy), .err(err)
  );

  uart_tx_arbiter #(
    .N_REQ(N), .BIT_MAX(W), .GAP_CYCLES(10), .ACCEPT_TIMEOUT(4)
  ) dut_gap (
    .clk(clk), .rst(rst), .req(g_req), .req_data(g_data), .req_last(g_last),
    .ack(g_ack), .grant(g_grant), .tx_data(g_tx_data), .tx_start(g_tx_start),
    .tx_ready(g_tx_ready), .busy(g_busy), .err(g_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] c, input int from);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (from + k) % N;
      if (c[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: predict an IDLE win from the rules, then check the pulses after the edge
  task automatic step();
    logic [N-1:0]   cand;
    logic [N*W-1:0] dat_s;
    logic [N-1:0]   last_s;
    int             w;
    w = -1;
    if (!busy) begin
      cand = m_lock ? (req & (N'(1) << m_last)) : req;
      w = rr_winner(cand, m_last);
    end
    dat_s  = req_data;
    last_s = req_last;
    @(posedge clk);
    @(negedge clk);
    if (tx_ready && !prev_rdy) last_rise = cyc;
    prev_rdy = tx_ready;
    if (w >= 0) begin
      check("win_ack",   32'(ack),      32'(N'(1) << w));
      check("win_start", 32'(tx_start), 32'd1);
      check("win_grant", 32'(grant),    32'(N'(1) << w));
      check("win_data",  32'(tx_data),  32'(dat_s[w*W +: W]));
      served.push_back(w);
      start_delta.push_back(cyc - last_rise);
      m_last = w;
      m_lock = !last_s[w];
    end else begin
      check("quiet_pulse", 32'({ack, tx_start}), 32'd0);
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    req      = '0;
    req_last = '0;
    req_data = '0;
    g_req    = '0;
    g_last   = '0;
    g_data   = '0;
    m_last   = N - 1;
    m_lock   = 1'b0;
    prev_rdy = 1'b1;
    last_rise = -1000;
    served.delete();
    start_delta.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack",      32'(ack),      32'd0);
    check("rst_grant",    32'(grant),    32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single request
    req_data[7:0] = 8'h55;
    req_last      = 4'b0001;
    req           = 4'b0001;
    step();
    req = '0;
    check("t1_served", served.size(), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1", 200);
    check("t1_idle_after_rise", cyc - last_rise, 32'd1);
    check("t1_grant_clear", 32'(grant), 32'd0);

    // All four requesting, held
    do_reset();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_last = '1;
    req      = '1;
    for (int n = 0; n < 600 && served.size() < 5; n++) step();
    req = '0;
    check("t2_count", served.size(), 32'd5);
    for (int i = 0; i < 5 && i < served.size(); i++) check("t2_order", served[i], t2_exp[i]);
    for (int i = 1; i < 5 && i < start_delta.size(); i++) check("t2_start_delay", start_delta[i], 32'd2);
    wait_idle("t2", 200);

    // Packet lock: requester 2 sends three bytes, requester 0 waits
    do_reset();
    req_data[2*W +: W] = 8'hC0;
    req_last[2]        = 1'b0;
    req[2]             = 1'b1;
    b    = 0;
    hold = 0;
    for (int n = 0; n < 1000 && served.size() < 4; n++) begin
      step();
      if (ack[2]) begin
        b++;
        if (b == 1) begin
          req[2]        = 1'b0;
          hold          = 80;
          req_data[7:0] = 8'h10;
          req_last[0]   = 1'b1;
          req[0]        = 1'b1;
        end else if (b == 2) begin
          req_data[2*W +: W] = 8'hC2;
          req_last[2]        = 1'b1;
        end else begin
          req[2] = 1'b0;
        end
      end
      if (ack[0]) req[0] = 1'b0;
      if (hold > 0) begin
        hold--;
        if (hold == 10) begin
          check("t3_locked_grant", 32'(grant), 32'h4);
          check("t3_locked_idle",  32'(busy),  32'd0);
        end
        if (hold == 0) begin
          req_data[2*W +: W] = 8'hC1;
          req_last[2]        = 1'b0;
          req[2]             = 1'b1;
        end
      end
    end
    req = '0;
    check("t3_count", served.size(), 32'd4);
    for (int i = 0; i < 4 && i < served.size(); i++) check("t3_order", served[i], t3_exp[i]);
    wait_idle("t3", 200);

    // Gap instance: second start 12 clocks after first tx_ready rise
    do_reset();
    g_data[7:0] = 8'h31;
    g_last      = 4'b0001;
    g_req       = 4'b0001;
    @(negedge clk);
    check("t4_ack1",   32'(g_ack),      32'd1);
    check("t4_start1", 32'(g_tx_start), 32'd1);
    g_data[7:0] = 8'h32;
    g_rise   = -1000;
    g_start  = -1;
    seen_low = 1'b0;
    for (int n = 0; n < 200 && g_start < 0; n++) begin
      @(negedge clk);
      if (!g_tx_ready) seen_low = 1'b1;
      else if (seen_low && g_rise < 0) g_rise = cyc;
      if (g_tx_start) g_start = cyc;
    end
    g_req = '0;
    check("t4_gap_delay", g_start - g_rise, 32'd12);
    check("t4_data2", 32'(g_tx_data), 32'h32);
    check("t4_ack2",  32'(g_ack),     32'd1);

    // Dead transmitter: accept timeout
    do_reset();
    tx_dead         = 1'b1;
    req_data[15:0]  = 16'h7877;
    req_last        = 4'b0011;
    req             = 4'b0001;
    step();
    req = '0;
    for (int n = 0; n < 3; n++) begin
      step();
      check("t5_err_early", 32'(err), 32'd0);
    end
    step();
    check("t5_err",   32'(err),   32'd1);
    check("t5_idle",  32'(busy),  32'd0);
    check("t5_grant", 32'(grant), 32'd0);
    repeat (5) step();
    check("t5_err_sticky", 32'(err), 32'd1);
    req = 4'b0010;
    step();
    req = '0;
    check("t5_rearb", served.size(), 32'd2);
    wait_idle("t5", 20);
    check("t5_err_hold", 32'(err), 32'd1);
    tx_dead = 1'b0;

    // Reset in the middle of a byte
    do_reset();
    req_data[23:16] = 8'h66;
    req_last        = 4'b0100;
    req             = 4'b0100;
    step();
    req = '0;
    repeat (5) step();
    check("t6_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_ack",      32'(ack),      32'd0);
    check("t6_grant",    32'(grant),    32'd0);
    check("t6_tx_data",  32'(tx_data),  32'd0);
    check("t6_tx_start", 32'(tx_start), 32'd0);
    check("t6_busy_rst", 32'(busy),     32'd0);
    check("t6_err",      32'(err),      32'd0);
    m_last = N - 1;
    m_lock = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    prev_rdy = 1'b1;
    @(negedge clk);
    req_data[7:0] = 8'h01;
    req_last      = 4'b0101;
    req           = 4'b0101;
    step();
    check("t6_first_winner", 32'(ack), 32'd1);
    req = '0;
    wait_idle("t6", 200);

    // Random traffic against the round-robin/lock model
    do_reset();
    for (int n = 0; n < 5000 && served.size() < 40; n++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if (!req_last[i]) req[i] = 1'b1;
          else req[i] = 1'($urandom_range(0, 1));
          req_data[i*W +: W] = 8'($urandom);
          req_last[i]        = ($urandom_range(0, 2) != 0);
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i]             = 1'b1;
          req_data[i*W +: W] = 8'($urandom);
          req_last[i]        = ($urandom_range(0, 2) != 0);
        end
      end
    end
    req = '0;
    check("rand_count", served.size(), 32'd40);
    wait_idle("rand", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
